operand_fetch_rf: RTL

Operand-fetch and register-file stage feeding the CPU's execute path (16-bit add/sub/mul/div selected by `f0`). Holds the 16 x 16-bit architectural registers that the execute stage's result demux writes back into, reads the `rs1`/`rs2` operands by index, and hands operand pairs to execute over a valid/ready handshake. A per-register scoreboard stalls issue while a source or destination register has a result still in flight; same-cycle writeback is bypassed to the operands.

---
 rtl/operand_fetch_rf.sv | 137 +++++++++++++
 1 files changed

// File: rtl/operand_fetch_rf.sv
// Operand-fetch / register-file stage: 16 x 16-bit registers, a per-register
// pending-write scoreboard, writeback bypass, and a valid/ready operand pair to execute.
module operand_fetch_rf #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [1:0]        iss_f0,
    input  logic [IDX_W-1:0]  iss_rd,
    input  logic [IDX_W-1:0]  iss_rs1,
    input  logic [IDX_W-1:0]  iss_rs2,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [1:0]        ex_f0,
    output logic [IDX_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [NREG-1:0]   busy_mask
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              ex_valid_q, ex_valid_d;
    logic [1:0]        ex_f0_q, ex_f0_d;
    logic [IDX_W-1:0]  ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
    logic [DATA_W-1:0] ex_op2_q, ex_op2_d;

    logic [NREG-1:0]   wb_clr_s;
    logic [NREG-1:0]   busy_eff_s;
    logic              hazard_s;
    logic              accept_s;
    logic [DATA_W-1:0] op1_byp_s, op2_byp_s;

    // Hazard detection: a same-cycle writeback releases its register for issue.
    always_comb begin
        wb_clr_s = {NREG{1'b0}};
        if (wb_valid) begin
            wb_clr_s[wb_rd] = 1'b1;
        end else begin
            wb_clr_s = {NREG{1'b0}};
        end
        busy_eff_s = busy_q & ~wb_clr_s;
        hazard_s   = busy_eff_s[iss_rs1] | busy_eff_s[iss_rs2] | busy_eff_s[iss_rd];
        iss_ready  = !hazard_s && (!ex_valid_q || ex_ready);
        accept_s   = iss_valid && iss_ready;
    end

    // Operand read with writeback bypass.
    always_comb begin
        if (wb_valid && (wb_rd == iss_rs1)) begin
            op1_byp_s = wb_data;
        end else begin
            op1_byp_s = regs_q[iss_rs1];
        end
        if (wb_valid && (wb_rd == iss_rs2)) begin
            op2_byp_s = wb_data;
        end else begin
            op2_byp_s = regs_q[iss_rs2];
        end
    end

    // Register file and scoreboard next state; an accepted set beats a same-cycle clear.
    always_comb begin
        regs_d = regs_q;
        if (wb_valid) begin
            regs_d[wb_rd] = wb_data;
        end else begin
            regs_d = regs_q;
        end
        busy_d = busy_eff_s;
        if (accept_s) begin
            busy_d[iss_rd] = 1'b1;
        end else begin
            busy_d = busy_eff_s;
        end
    end

    // Output pair next state: load on accept, drop on consume, otherwise hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_f0_d    = ex_f0_q;
        ex_rd_d    = ex_rd_q;
        ex_op1_d   = ex_op1_q;
        ex_op2_d   = ex_op2_q;
        if (accept_s) begin
            ex_valid_d = 1'b1;
            ex_f0_d    = iss_f0;
            ex_rd_d    = iss_rd;
            ex_op1_d   = op1_byp_s;
            ex_op2_d   = op2_byp_s;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // State registers with synchronous, dominant reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
            busy_q     <= {NREG{1'b0}};
            ex_valid_q <= 1'b0;
            ex_f0_q    <= 2'b00;
            ex_rd_q    <= {IDX_W{1'b0}};
            ex_op1_q   <= {DATA_W{1'b0}};
            ex_op2_q   <= {DATA_W{1'b0}};
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            ex_f0_q    <= ex_f0_d;
            ex_rd_q    <= ex_rd_d;
            ex_op1_q   <= ex_op1_d;
            ex_op2_q   <= ex_op2_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_f0     = ex_f0_q;
    assign ex_rd     = ex_rd_q;
    assign ex_op1    = ex_op1_q;
    assign ex_op2    = ex_op2_q;
    assign busy_mask = busy_q;

endmodule
